jtag_dmi_master: RTL and testbench

DTM-side DMI agent, the initiator that talks to the debug module across its 4-phase req/ack handshake. It accepts one DMI request per transaction from the JTAG TAP logic, transmits it to the DM, and waits for the DM response. It returns that response to the TAP logic and maintains the sticky DMI status. It synchronizes every incoming handshake signal into its own clock domain.

---
 rtl/jtag_dmi_master_pkg.sv | 28 ++
 rtl/dmi_sync2.sv | 22 ++
 rtl/jtag_dmi_master.sv | 136 +++++++++++++
 tb/tb_jtag_dmi_master.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dmi_master_pkg.sv
// Shared DMI field widths, op/status codes and agent FSM states.
// Imported by the DTM-side DMI agent.
package jtag_dmi_master_pkg;

  localparam int DMI_ADDR_W = 6;
  localparam int DMI_DATA_W = 32;
  localparam int DMI_OP_W   = 2;

  typedef enum logic [1:0] {
    DTM_OP_NOP   = 2'b00,
    DTM_OP_READ  = 2'b01,
    DTM_OP_WRITE = 2'b10
  } dtm_op_e;

  typedef enum logic [1:0] {
    DMI_STAT_OK     = 2'b00,
    DMI_STAT_FAILED = 2'b10,
    DMI_STAT_BUSY   = 2'b11
  } dmi_stat_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ_HI,
    REQ_LO,
    WAIT_DONE
  } dmi_state_e;

endpackage

// File: rtl/dmi_sync2.sv
// 1-bit two-flop synchronizer, async active-low reset.
// Ports: clk, rst_n, d (async in), q (synchronized out).
module dmi_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/jtag_dmi_master.sv
// DTM-side DMI initiator: TAP request -> 4-phase req/ack to DM -> response.
// Ports: TAP side dmi_*, DM side dtm_req_*/dm_ack/dm_resp_*/dtm_ack, status.
module jtag_dmi_master
  import jtag_dmi_master_pkg::*;
#(
  parameter int DMI_ADDR_BITS = DMI_ADDR_W,
  parameter int DMI_DATA_BITS = DMI_DATA_W,
  parameter int DMI_OP_BITS   = DMI_OP_W,
  parameter int DMI_REQ_BITS  = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dmi_req_valid_i,
  output logic                    dmi_req_ready_o,
  input  logic [DMI_REQ_BITS-1:0] dmi_req_data_i,
  output logic                    dmi_rsp_valid_o,
  output logic [DMI_REQ_BITS-1:0] dmi_rsp_data_o,
  output logic                    dmi_busy_o,
  output logic [1:0]              dmi_stat_o,
  input  logic                    dmireset_i,
  input  logic                    dmihardreset_i,
  output logic                    dtm_req_valid_o,
  output logic [DMI_REQ_BITS-1:0] dtm_req_data_o,
  input  logic                    dm_ack_i,
  input  logic                    dm_resp_valid_i,
  input  logic [DMI_REQ_BITS-1:0] dm_resp_data_i,
  output logic                    dtm_ack_o
);

  logic       ack_s;
  logic       rv_s;
  dmi_state_e state;
  dmi_state_e state_n;
  logic       abort;
  logic       abort_eff;
  logic       rsp_got;
  logic       accept;
  logic       violate;
  logic       to_idle;
  logic       capture;
  logic [1:0] rsp_op;
  logic [1:0] stat_n;

  dmi_sync2 u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dm_ack_i),
    .q     (ack_s)
  );

  dmi_sync2 u_rv_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dm_resp_valid_i),
    .q     (rv_s)
  );

  assign dmi_req_ready_o = (state == IDLE);
  assign dmi_busy_o      = (state != IDLE);

  assign accept  = dmi_req_valid_i && (state == IDLE);
  assign violate = dmi_req_valid_i && (state != IDLE);
  assign to_idle = (state != IDLE) && (state_n == IDLE);
  assign capture = rv_s && !dtm_ack_o && !rsp_got;
  assign rsp_op  = dm_resp_data_i[1:0];

  // A hard reset seen this cycle already counts as aborting.
  assign abort_eff = abort ||
                     (dmihardreset_i && (state != IDLE));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (dmi_req_valid_i) state_n = REQ_HI;
      REQ_HI:    if (ack_s) state_n = REQ_LO;
      REQ_LO:    if (!ack_s) state_n = WAIT_DONE;
      WAIT_DONE: if (rsp_got && !rv_s && !dtm_ack_o)
                   state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Clears take priority over any flag raised the same cycle.
  always_comb begin
    stat_n = dmi_stat_o;
    if (capture && rsp_op[1]) stat_n = stat_n | rsp_op;
    if (violate) stat_n = DMI_STAT_BUSY;
    if (dmireset_i ||
        (dmihardreset_i && (state == IDLE)) ||
        (to_idle && abort_eff))
      stat_n = DMI_STAT_OK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dtm_req_valid_o <= 1'b0;
      dtm_req_data_o  <= '0;
      abort           <= 1'b0;
      dmi_stat_o      <= 2'b00;
    end else begin
      dtm_req_valid_o <= (state_n == REQ_HI);
      if (accept) dtm_req_data_o <= dmi_req_data_i;
      abort           <= abort_eff && !to_idle;
      dmi_stat_o      <= stat_n;
    end
  end

  // Response handshake runs regardless of request phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dtm_ack_o       <= 1'b0;
      rsp_got         <= 1'b0;
      dmi_rsp_valid_o <= 1'b0;
      dmi_rsp_data_o  <= '0;
    end else begin
      dmi_rsp_valid_o <= capture && !abort_eff;
      if (capture) begin
        dmi_rsp_data_o <= dm_resp_data_i;
        dtm_ack_o      <= 1'b1;
      end else if (!rv_s && dtm_ack_o) begin
        dtm_ack_o <= 1'b0;
      end
      if (to_idle) rsp_got <= 1'b0;
      else if (capture) rsp_got <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_dmi_master.sv
// Directed bench for jtag_dmi_master with a DM handshake model.
// Per-cycle compare process plus end-of-transaction checks.
module tb_jtag_dmi_master;

  localparam int RB = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dmi_req_valid_i = 1'b0;
  logic          dmi_req_ready_o;
  logic [RB-1:0] dmi_req_data_i = '0;
  logic          dmi_rsp_valid_o;
  logic [RB-1:0] dmi_rsp_data_o;
  logic          dmi_busy_o;
  logic [1:0]    dmi_stat_o;
  logic          dmireset_i = 1'b0;
  logic          dmihardreset_i = 1'b0;
  logic          dtm_req_valid_o;
  logic [RB-1:0] dtm_req_data_o;
  logic          dm_ack_i = 1'b0;
  logic          dm_resp_valid_i = 1'b0;
  logic [RB-1:0] dm_resp_data_i = '0;
  logic          dtm_ack_o;

  jtag_dmi_master dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dmi_req_valid_i (dmi_req_valid_i),
    .dmi_req_ready_o (dmi_req_ready_o),
    .dmi_req_data_i  (dmi_req_data_i),
    .dmi_rsp_valid_o (dmi_rsp_valid_o),
    .dmi_rsp_data_o  (dmi_rsp_data_o),
    .dmi_busy_o      (dmi_busy_o),
    .dmi_stat_o      (dmi_stat_o),
    .dmireset_i      (dmireset_i),
    .dmihardreset_i  (dmihardreset_i),
    .dtm_req_valid_o (dtm_req_valid_o),
    .dtm_req_data_o  (dtm_req_data_o),
    .dm_ack_i        (dm_ack_i),
    .dm_resp_valid_i (dm_resp_valid_i),
    .dm_resp_data_i  (dm_resp_data_i),
    .dtm_ack_o       (dtm_ack_o)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  int            pulses = 0;
  logic [RB-1:0] exp_req = '0;
  logic [RB-1:0] exp_rsp = '0;
  logic [1:0]    exp_stat = 2'b00;
  bit            pulse_ok = 1'b1;
  bit            ack_done = 1'b0;

  function automatic void chk(input string name,
                              input logic [63:0] got,
                              input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return dtm_req_valid_o;
      1:       return dtm_ack_o;
      2:       return dmi_busy_o;
      default: return ack_done;
    endcase
  endfunction

  task automatic wait_sig(input int which, input bit lvl,
                          input string name);
    int k;
    k = 0;
    while (sig(which) !== lvl && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      total++;
      bad++;
      $display("FAIL timeout %s: got %0b want %0b",
               name, !lvl, lvl);
    end
  endtask

  // Every-cycle model checks.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("ready_vs_busy", dmi_req_ready_o, !dmi_busy_o);
      chk("req_data", dtm_req_data_o, exp_req);
      if (dtm_req_valid_o)
        chk("req_valid_busy", dmi_busy_o, 1);
      if (dmi_rsp_valid_o) begin
        pulses++;
        chk("pulse_allowed", pulse_ok, 1);
        chk("rsp_data", dmi_rsp_data_o, exp_rsp);
      end
    end
  end

  task automatic run_txn(input logic [RB-1:0] req,
                         input logic [RB-1:0] rsp,
                         input int ack_dly,
                         input bit early,
                         input int rsp_dly,
                         input bit violate,
                         input bit hreset);
    int p0;
    @(negedge clk);
    exp_req  = req;
    exp_rsp  = rsp;
    pulse_ok = !hreset;
    ack_done = 1'b0;
    p0       = pulses;
    dmi_req_data_i  = req;
    dmi_req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_req_valid", dtm_req_valid_o, 1);
    chk("accept_busy", dmi_busy_o, 1);
    chk("accept_ready", dmi_req_ready_o, 0);
    @(negedge clk);
    dmi_req_valid_i = 1'b0;
    fork
      begin
        wait_sig(0, 1, "req_hi");
        repeat (ack_dly) @(negedge clk);
        dm_ack_i = 1'b1;
        wait_sig(0, 0, "req_lo");
        if (hreset) begin
          dmihardreset_i = 1'b1;
          @(negedge clk);
          dmihardreset_i = 1'b0;
        end
        repeat (2) @(negedge clk);
        dm_ack_i = 1'b0;
        ack_done = 1'b1;
      end
      begin
        if (early) wait_sig(0, 1, "req_hi_rsp");
        else wait_sig(3, 1, "ack_done");
        repeat (rsp_dly) @(negedge clk);
        dm_resp_data_i  = rsp;
        dm_resp_valid_i = 1'b1;
        wait_sig(1, 1, "dtm_ack_hi");
        dm_resp_valid_i = 1'b0;
        wait_sig(1, 0, "dtm_ack_lo");
      end
      begin
        if (violate) begin
          wait_sig(0, 1, "req_hi_viol");
          repeat (2) @(negedge clk);
          dmi_req_data_i  = ~req;
          dmi_req_valid_i = 1'b1;
          @(negedge clk);
          dmi_req_valid_i = 1'b0;
        end
      end
    join
    wait_sig(2, 0, "return_idle");
    if (hreset) exp_stat = 2'b00;
    else begin
      if (rsp[1]) exp_stat = exp_stat | rsp[1:0];
      if (violate) exp_stat = 2'b11;
    end
    @(negedge clk);
    chk("stat", dmi_stat_o, exp_stat);
    chk("pulse_count", pulses - p0, hreset ? 0 : 1);
    chk("hs_idle", {dtm_req_valid_o, dtm_ack_o}, 0);
  endtask

  task automatic do_dmireset();
    @(negedge clk);
    dmireset_i = 1'b1;
    @(negedge clk);
    dmireset_i = 1'b0;
    exp_stat = 2'b00;
    chk("dmireset_stat", dmi_stat_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RB-1:0] r;
    @(negedge clk);
    chk("rst_ready", dmi_req_ready_o, 1);
    chk("rst_outs",
        {dmi_rsp_valid_o, dmi_busy_o, dmi_stat_o,
         dtm_req_valid_o, dtm_ack_o}, 0);
    chk("rst_data", {dmi_rsp_data_o, dtm_req_data_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn({6'h10, 32'h8000_0001, 2'b10},
            {6'h10, 32'h0, 2'b00}, 5, 0, 2, 0, 0);
    chk("write_literal", dtm_req_data_o, 40'h42_0000_0006);

    run_txn({6'h11, 32'h0, 2'b01},
            {6'h11, 32'h0043_0c82, 2'b00}, 12, 1, 1, 0, 0);
    chk("early_rsp_literal", dmi_rsp_data_o, 40'h44_010c_3208);

    run_txn({6'h04, 32'h1234_5678, 2'b10},
            {6'h04, 32'h0, 2'b00}, 8, 0, 1, 1, 0);
    chk("viol_literal", dmi_stat_o, 2'b11);
    do_dmireset();

    run_txn({6'h05, 32'h0, 2'b01},
            {6'h05, 32'hdead_beef, 2'b10}, 3, 0, 2, 0, 0);
    run_txn({6'h06, 32'h0, 2'b01},
            {6'h06, 32'h0000_0042, 2'b00}, 4, 1, 3, 0, 0);
    chk("sticky_literal", dmi_stat_o, 2'b10);
    do_dmireset();

    run_txn({6'h07, 32'h5, 2'b10},
            {6'h07, 32'h77, 2'b11}, 4, 0, 2, 0, 1);
    chk("abort_ready", dmi_req_ready_o, 1);
    run_txn({6'h08, 32'h9, 2'b10},
            {6'h08, 32'h0, 2'b00}, 2, 0, 1, 0, 0);

    r = {6'h09, 32'hcafe_f00d, 2'b10};
    @(negedge clk);
    exp_req = r;
    dmi_req_data_i  = r;
    dmi_req_valid_i = 1'b1;
    @(negedge clk);
    dmi_req_valid_i = 1'b0;
    wait_sig(0, 1, "rst_req_hi");
    #2;
    rst_n = 1'b0;
    exp_req = '0;
    exp_stat = 2'b00;
    #1;
    chk("async_outs",
        {dmi_rsp_valid_o, dmi_busy_o, dmi_stat_o,
         dtm_req_valid_o, dtm_ack_o}, 0);
    chk("async_data", {dmi_rsp_data_o, dtm_req_data_o}, 0);
    chk("async_ready", dmi_req_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", dmi_req_ready_o, 1);
    run_txn({6'h0a, 32'h3, 2'b01},
            {6'h0a, 32'h1234, 2'b00}, 3, 0, 1, 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
